// File: rtl/hier_report_collector.sv
// hier_report_collector: round-robin fan-in of child reports into a small FIFO toward the parent,
// tagging each entry with the index of the child that produced it.
module hier_report_collector #(
    parameter int NUM_CHILD  = 15,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    localparam int IDX_W     = $clog2(NUM_CHILD)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CHILD-1:0]        child_valid,
    input  logic [NUM_CHILD*DATA_W-1:0] child_data,
    output logic [NUM_CHILD-1:0]        child_ready,
    output logic                        up_valid,
    input  logic                        up_ready,
    output logic [IDX_W+DATA_W-1:0]     up_data,
    output logic [CNT_W-1:0]            report_cnt,
    output logic                        idle
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d, gnt_idx;
    logic [PTR_W:0]          count_q, count_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [IDX_W+DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [IDX_W+DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    push, pop, space, any_valid;
    int                      j;

    // Scan downward so the last hit is the nearest valid child at or after rr_ptr.
    always_comb begin
        space     = count_q < (PTR_W+1)'(FIFO_DEPTH);
        any_valid = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int k = NUM_CHILD - 1; k >= 0; k--) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_CHILD) j = j - NUM_CHILD;
            if (child_valid[j]) begin
                any_valid = 1'b1;
                gnt_idx   = IDX_W'(j);
            end
        end
        push        = any_valid && space && rst_n;
        child_ready = push ? (NUM_CHILD'(1) << gnt_idx) : '0;
    end

    always_comb begin
        up_valid   = count_q != '0;
        pop        = up_valid && up_ready;
        up_data    = up_valid ? mem_q[rd_ptr_q] : '0;
        report_cnt = cnt_q;
        idle       = (count_q == '0) && (child_valid == '0);
        rr_ptr_d   = push ? ((gnt_idx == IDX_W'(NUM_CHILD - 1)) ? '0 : gnt_idx + 1'b1) : rr_ptr_q;
        count_d    = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        wr_ptr_d   = wr_ptr_q + {{(PTR_W-1){1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};
        cnt_d      = (push && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        mem_d      = mem_q;
        if (push) mem_d[wr_ptr_q] = {gnt_idx, child_data[gnt_idx*DATA_W +: DATA_W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: up_data is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_hier_report_collector.sv
// tb_hier_report_collector: directed and random stimulus checked against a queue-based model.
module tb_hier_report_collector;
    localparam int NC = 15;
    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NC-1:0]   cv = '0;
    logic [NC*DW-1:0] cd = '0;
    logic            up_ready = 1'b0;
    logic [NC-1:0]   child_ready, child_ready_s;
    logic            up_valid, up_valid_s, idle, idle_s;
    logic [11:0]     up_data, up_data_s;
    logic [15:0]     report_cnt;
    logic [3:0]      report_cnt_s;

    int checks = 0;
    int errors = 0;
    logic [11:0] q[$];
    int rr = 0;
    int cnt = 0;
    logic [NC-1:0] acc = '0;

    hier_report_collector dut (
        .clk(clk), .rst_n(rst_n), .child_valid(cv), .child_data(cd),
        .child_ready(child_ready), .up_valid(up_valid), .up_ready(up_ready),
        .up_data(up_data), .report_cnt(report_cnt), .idle(idle)
    );

    hier_report_collector #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .child_valid(cv), .child_data(cd),
        .child_ready(child_ready_s), .up_valid(up_valid_s), .up_ready(up_ready),
        .up_data(up_data_s), .report_cnt(report_cnt_s), .idle(idle_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        rr = 0;
        cnt = 0;
        acc = '0;
    endtask

    // One clock of the reference: arbitrate from the queue occupancy, compare, then commit.
    task automatic cycle();
        int gi;
        logic [NC-1:0] eg;
        logic popd;
        @(negedge clk);
        gi = -1;
        eg = '0;
        if (q.size() < DEPTH)
            for (int k = 0; k < NC; k++)
                if (gi < 0 && cv[(rr + k) % NC]) gi = (rr + k) % NC;
        if (gi >= 0) eg[gi] = 1'b1;
        chk("child_ready", 32'(child_ready), 32'(eg));
        chk("up_valid", 32'(up_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("up_data", 32'(up_data), 32'(q[0]));
        chk("report_cnt", 32'(report_cnt), 32'(cnt));
        chk("sat_cnt", 32'(report_cnt_s), 32'(cnt > 15 ? 15 : cnt));
        chk("idle", 32'(idle), 32'(q.size() == 0 && cv == '0));
        popd = up_ready && q.size() != 0;
        @(posedge clk);
        if (popd) void'(q.pop_front());
        if (gi >= 0) begin
            q.push_back({4'(gi), cd[gi*DW +: DW]});
            rr = (gi + 1) % NC;
            if (cnt < 65535) cnt++;
        end
        acc = eg;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cv = '0;
        up_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    task automatic rand_step(input int pv);
        for (int i = 0; i < NC; i++) begin
            if (acc[i]) cv[i] = 1'b0;
            if (!cv[i] && $urandom_range(99) < pv) begin
                cv[i] = 1'b1;
                cd[i*DW +: DW] = 8'($urandom);
            end
        end
        up_ready = $urandom_range(99) < 60;
    endtask

    initial begin
        cv = 15'h7FFF;
        #3;
        chk("rst_child_ready", 32'(child_ready), 0);
        chk("rst_up_valid", 32'(up_valid), 0);
        chk("rst_up_data", 32'(up_data), 0);
        chk("rst_report_cnt", 32'(report_cnt), 0);
        do_reset();

        cv[5] = 1'b1;
        cd[5*DW +: DW] = 8'hA5;
        up_ready = 1'b1;
        #1 chk("single_gnt", 32'(child_ready), 32'h20);
        cycle();
        cv = '0;
        #1;
        chk("single_valid", 32'(up_valid), 1);
        chk("single_data", 32'(up_data), 32'h5A5);
        chk("single_cnt", 32'(report_cnt), 1);
        cycle();

        do_reset();
        cv = '1;
        for (int i = 0; i < NC; i++) cd[i*DW +: DW] = 8'(i);
        up_ready = 1'b1;
        for (int i = 0; i < NC; i++) begin
            cycle();
            cv = cv & ~acc;
        end
        repeat (2) cycle();
        chk("contend_cnt", 32'(report_cnt), 15);

        do_reset();
        cv[0] = 1'b1;
        cv[14] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cycle();
            for (int c = 0; c < NC; c++) if (acc[c]) cd[c*DW +: DW] = 8'($urandom);
        end
        chk("full_no_grant", 32'(child_ready), 0);
        chk("full_cnt", 32'(report_cnt), 4);
        up_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            for (int c = 0; c < NC; c++) if (acc[c]) cd[c*DW +: DW] = 8'($urandom);
        end

        do_reset();
        cv[2] = 1'b1;
        up_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            cv[2] = ~cv[2];
        end
        chk("sat_hold", 32'(report_cnt_s), 15);
        chk("wide_cnt", 32'(report_cnt), 20);

        do_reset();
        cv[1] = 1'b1;
        repeat (3) cycle();
        cv = '0;
        #2 rst_n = 1'b0;
        cv[3] = 1'b1;
        #1;
        chk("midrst_up_valid", 32'(up_valid), 0);
        chk("midrst_cnt", 32'(report_cnt), 0);
        chk("midrst_ready", 32'(child_ready), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_clear();
        #1 chk("midrst_first_gnt", 32'(child_ready), 32'h8);
        cycle();
        cv = '0;
        cycle();

        do_reset();
        cv[7] = 1'b1;
        repeat (2) cycle();
        up_ready = 1'b1;
        cycle();
        chk("pushpop_depth", 32'(q.size()), 2);
        cv = '0;
        repeat (4) cycle();
        chk("drain_idle", 32'(idle), 1);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rand_step(i < 1500 ? 30 : 80);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
